// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B Gray code) position decoder.
//   Synchronizes and debounces channels a/b, decodes the filtered pair
//   against the previous pair and keeps an up/down position count.
// Ports:
//   clk      - sole clock, rising edge
//   reset    - asynchronous active-high reset
//   a, b     - raw quadrature channels (asynchronous to clk)
//   clear    - synchronous clear of value (wins over a same-cycle event)
//   err_clr  - synchronous clear of error (a same-cycle violation wins)
//   value    - WIDTH-bit position count (wraps or saturates per SAT)
//   step     - one-cycle pulse per counted event
//   dir      - direction of last counted event, 1 = CW, 0 = CCW
//   error    - sticky flag: both filtered channels changed in one cycle
module quad_decoder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FILTER = 4,
    parameter int unsigned RES    = 2,
    parameter int unsigned SAT    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    input  logic             err_clr,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             error
);

    localparam int unsigned SU_LEN = FILTER + 3;
    localparam int unsigned SU_W   = $clog2(SU_LEN + 1);
    localparam int unsigned CNT_W  = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       sy;       // synchronized pair {a,b}
    logic [1:0]       filt;     // filtered pair {fa,fb}
    logic [1:0]       prev;     // previous filtered pair {oa,ob}
    logic [SU_W-1:0]  su_cnt;
    logic             startup_c;
    logic [1:0]       delta_c;
    logic             cw_c;
    logic             ccw_c;
    logic             illegal_c;
    logic             qual_c;
    logic             event_c;
    logic [WIDTH-1:0] val_nxt_c;

    // Position of a pair along the CW sequence 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Two-flop synchronizers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], a};
            sync_b <= {sync_b[0], b};
        end
    end

    assign sy = {sync_a[1], sync_b[1]};

    // Startup window: filter bypassed, prev tracks filt, no events or errors.
    assign startup_c = (su_cnt != SU_W'(SU_LEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            su_cnt <= '0;
        end else if (startup_c) begin
            su_cnt <= su_cnt + SU_W'(1);
        end
    end

    // Debounce: accept a differing level after FILTER stable cycles.
    // For a single bit, a change of sy while it differs from filt means
    // it returned to filt, so the equality test covers both reset causes.
    if (FILTER == 0) begin : g_nofilt
        assign filt = sy;
    end else begin : g_filt
        logic [CNT_W-1:0] cnt [2];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                filt   <= '0;
                cnt[0] <= '0;
                cnt[1] <= '0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (startup_c) begin
                        filt[i] <= sy[i];
                        cnt[i]  <= '0;
                    end else if (sy[i] == filt[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_W'(FILTER - 1)) begin
                        filt[i] <= sy[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Transition decode: distance along the Gray sequence, mod 4.
    assign delta_c   = gray_pos(filt) - gray_pos(prev);
    assign cw_c      = (delta_c == 2'd1);
    assign ccw_c     = (delta_c == 2'd3);
    assign illegal_c = (delta_c == 2'd2) && !startup_c;

    // Resolution qualifier: which legal transitions are counted
    always_comb begin
        qual_c = 1'b1;
        if (RES == 2) begin
            qual_c = prev[1] ^ filt[1];
        end else if (RES == 1) begin
            qual_c = (filt == 2'b00);
        end
    end

    assign event_c = (cw_c || ccw_c) && qual_c && !startup_c;

    // Next count with wrap or saturation at 0 / MAX_VAL
    always_comb begin
        val_nxt_c = value;
        if (cw_c) begin
            if (!(SAT != 0 && value == MAX_VAL)) begin
                val_nxt_c = value + WIDTH'(1);
            end
        end else begin
            if (!(SAT != 0 && value == '0)) begin
                val_nxt_c = value - WIDTH'(1);
            end
        end
    end

    // Decode register and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= '0;
            value <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            error <= 1'b0;
        end else begin
            prev <= filt;
            step <= 1'b0;
            if (clear) begin
                value <= '0;
            end else if (event_c) begin
                value <= val_nxt_c;
                step  <= 1'b1;
                dir   <= cw_c;
            end
            if (illegal_c) begin
                error <= 1'b1;
            end else if (err_clr) begin
                error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: four instances (RES4 wrap, RES4 saturate,
// RES2 with FILTER=4, RES1) driven from shared inputs and compared with a
// per-instance transition-level reference model.
module tb_quad_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a = 1'b1;
    logic b = 1'b1;
    logic clear = 1'b0;
    logic err_clr = 1'b0;

    logic [7:0] val [4];
    logic       stp [4];
    logic       dr  [4];
    logic       er  [4];

    always #5 clk = ~clk;

    quad_decoder #(.WIDTH(8), .FILTER(0), .RES(4), .SAT(0)) u_r4w (
        .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
        .value(val[0]), .step(stp[0]), .dir(dr[0]), .error(er[0]));
    quad_decoder #(.WIDTH(8), .FILTER(0), .RES(4), .SAT(1)) u_r4s (
        .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
        .value(val[1]), .step(stp[1]), .dir(dr[1]), .error(er[1]));
    quad_decoder #(.WIDTH(8), .FILTER(4), .RES(2), .SAT(0)) u_r2f (
        .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
        .value(val[2]), .step(stp[2]), .dir(dr[2]), .error(er[2]));
    quad_decoder #(.WIDTH(8), .FILTER(0), .RES(1), .SAT(0)) u_r1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
        .value(val[3]), .step(stp[3]), .dir(dr[3]), .error(er[3]));

    int total = 0;
    int bad = 0;

    // Instance configuration
    int res_a  [4] = '{4, 4, 2, 1};
    int sat_a  [4] = '{0, 1, 0, 0};
    int filt_a [4] = '{0, 0, 4, 0};

    // Reference model state
    int m_val   [4];
    bit m_dir   [4];
    bit m_err   [4];
    int m_steps [4] = '{0, 0, 0, 0};
    int stepcnt [4] = '{0, 0, 0, 0};

    logic [1:0] cw_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] pr;

    // Observed step pulses, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (stp[i] === 1'b1) stepcnt[i]++;
        end
    end

    function automatic int gidx(input logic [1:0] ab);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            if (cw_seq[k] == ab) r = k;
        end
        return r;
    endfunction

    function automatic logic [1:0] cw_next(input logic [1:0] p);
        return cw_seq[(gidx(p) + 1) % 4];
    endfunction

    function automatic logic [1:0] ccw_next(input logic [1:0] p);
        return cw_seq[(gidx(p) + 3) % 4];
    endfunction

    task automatic model_step(input int i, input logic [1:0] p, input logic [1:0] c,
                              input bit suppress);
        int  d;
        bit  cw;
        bit  qual;
        d = (gidx(c) - gidx(p) + 4) % 4;
        cw = (d == 1);
        qual = (res_a[i] == 4) || (res_a[i] == 2 && p[1] != c[1]) ||
               (res_a[i] == 1 && c == 2'b00);
        if (d == 2) begin
            m_err[i] = 1'b1;
        end else if (d != 0 && qual && !suppress) begin
            m_steps[i]++;
            m_dir[i] = cw;
            if (cw) m_val[i] = (m_val[i] == 255) ? ((sat_a[i] != 0) ? 255 : 0) : m_val[i] + 1;
            else    m_val[i] = (m_val[i] == 0) ? ((sat_a[i] != 0) ? 0 : 255) : m_val[i] - 1;
        end
    endtask

    task automatic move(input logic [1:0] n, input bit to_f0, input bit to_f4, input bit supp_f0);
        for (int i = 0; i < 4; i++) begin
            if ((filt_a[i] == 0) ? to_f0 : to_f4)
                model_step(i, pr, n, (filt_a[i] == 0) && supp_f0);
        end
        pr = n;
        a = n[1];
        b = n[0];
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_val[i] = 0;
            m_dir[i] = 1'b0;
            m_err[i] = 1'b0;
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk_val($sformatf("%s value[%0d]", tag, i), val[i], 8'(m_val[i]));
            chk_bit($sformatf("%s dir[%0d]", tag, i), dr[i], m_dir[i]);
            chk_bit($sformatf("%s error[%0d]", tag, i), er[i], m_err[i]);
            chk_bit($sformatf("%s step[%0d]", tag, i), stp[i], 1'b0);
            total++;
            assert (stepcnt[i] === m_steps[i]) else begin
                bad++;
                $error("FAIL %s steps[%0d] got=%0d exp=%0d", tag, i, stepcnt[i], m_steps[i]);
            end
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) m_val[i] = 0;
        cyc(2);
    endtask

    initial begin
        int r;
        pr = 2'b11;
        model_reset();

        // Reset held with a=b=1, then startup window
        cyc(2);
        check_all("in_reset");
        reset = 1'b0;
        cyc(12);
        check_all("startup");

        // Full CW Gray cycle then full CCW Gray cycle
        repeat (4) begin move(cw_next(pr), 1, 1, 0); cyc(9); end
        check_all("cw_cycle");
        chk_val("cw_cycle r4w value", val[0], 8'd4);
        chk_bit("cw_cycle r4w dir", dr[0], 1'b1);
        repeat (4) begin move(ccw_next(pr), 1, 1, 0); cyc(9); end
        check_all("ccw_cycle");
        chk_val("ccw_cycle r4w value", val[0], 8'd0);
        chk_bit("ccw_cycle r4w dir", dr[0], 1'b0);

        // 3-cycle glitch on a: only the unfiltered instances see it
        move(2'b01, 1, 0, 0);
        cyc(3);
        move(2'b11, 1, 0, 0);
        cyc(12);
        check_all("glitch");

        // Clean edge on a: filtered RES2 step exactly 7 cycles later
        move(2'b01, 1, 1, 0);
        cyc(6);
        chk_bit("lat6 step", stp[2], 1'b0);
        cyc(1);
        chk_bit("lat7 step", stp[2], 1'b1);
        cyc(5);
        check_all("clean_edge");

        // Wrap and saturation at 255
        pulse_clear();
        check_all("clear0");
        repeat (255) begin move(cw_next(pr), 1, 1, 0); cyc(5); end
        cyc(10);
        check_all("at255");
        move(cw_next(pr), 1, 1, 0);
        cyc(10);
        check_all("past255");
        chk_val("wrap r4w", val[0], 8'd0);
        chk_val("sat r4s", val[1], 8'd255);
        chk_bit("sat r4s dir", dr[1], 1'b1);

        // Illegal transitions and err_clr priority
        move(~pr, 1, 1, 0);
        cyc(10);
        check_all("illegal1");
        move(~pr, 1, 1, 0);
        cyc(2);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk_bit("errclr_vs_illegal", er[0], 1'b1);
        cyc(10);
        check_all("illegal2");
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        for (int i = 0; i < 4; i++) m_err[i] = 1'b0;
        cyc(2);
        check_all("errclr");

        // clear coinciding with a counted CW event at value 5
        pulse_clear();
        repeat (5) begin move(cw_next(pr), 1, 1, 0); cyc(9); end
        check_all("at5");
        chk_val("at5 r4w", val[0], 8'd5);
        for (int i = 0; i < 4; i++) m_val[i] = 0;
        move(cw_next(pr), 1, 1, 1);
        cyc(2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk_bit("clr_evt step", stp[0], 1'b0);
        chk_val("clr_evt value", val[0], 8'd0);
        cyc(10);
        check_all("clr_evt");

        // Randomized walk with occasional illegal jumps
        repeat (30) begin
            r = $urandom_range(0, 9);
            if (r < 4)      move(cw_next(pr), 1, 1, 0);
            else if (r < 8) move(ccw_next(pr), 1, 1, 0);
            else if (r < 9) move(~pr, 1, 1, 0);
            cyc(9);
            check_all("rand");
        end

        // Reset mid-operation with an event in flight, then restart
        move(cw_next(pr), 0, 0, 0);
        cyc(1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        cyc(2);
        reset = 1'b0;
        cyc(12);
        check_all("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the position counter.
REQ-002 Parameter FILTER, default 4: debounce stability length in cycles; 0 disables the filter.
REQ-003 Parameter RES, default 2: counted resolution per Gray cycle; legal values 1, 2, 4.
REQ-004 Parameter SAT, default 0: 0 = counter wraps, 1 = counter saturates at 0 and 2^WIDTH-1.
REQ-005 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 a  input  1  quadrature channel A, asynchronous to clk.
REQ-008 b  input  1  quadrature channel B, asynchronous to clk.
REQ-009 clear  input  1  synchronous clear of value to 0.
REQ-010 err_clr  input  1  synchronous clear of the sticky error flag.
REQ-011 value  output  WIDTH  unsigned position count.
REQ-012 step  output  1  one-cycle pulse for each counted event.
REQ-013 dir  output  1  direction of the last counted event: 1 = CW, 0 = CCW.
REQ-014 error  output  1  sticky flag for an illegal transition, i.e. both channels changing in the same cycle.

Function
REQ-015 a and b shall each pass through a 2-flop synchronizer before any other logic.
REQ-016 Filter: each channel shall have a filtered bit and a stability counter.
- The counter resets to 0 whenever the synchronized value equals the filtered bit, or whenever the synchronized value changes.
- The filtered bit takes the synchronized value once the counter reaches FILTER.
- Net effect: a new level is accepted after FILTER consecutive stable differing cycles.
REQ-017 With FILTER=0 the filtered bit shall equal the synchronized bit, with no extra register stage.
REQ-018 Decode shall compare the previous filtered pair {oa,ob} with the current filtered pair {fa,fb}.
REQ-019 CW sequence on AB: 00->10->11->01->00. CCW is the reverse sequence.
REQ-020 An unchanged pair shall be idle: no step and no error.
REQ-021 A pair with both bits changed shall set error and shall not change value, step or dir.
REQ-022 RES=4 shall count all 4 CW and all 4 CCW transitions.
REQ-023 RES=2 shall count only transitions where A changes.
- CW: 00->10 and 11->01.
- CCW: 10->00 and 01->11.
REQ-024 RES=1 shall count only transitions into AB=00: CW 01->00, CCW 10->00.
REQ-025 A counted CW event shall increment value; a counted CCW event shall decrement it.
- In the same cycle: step=1, and dir is set to 1 for CW or 0 for CCW.
- value, step and dir are registered and appear on the cycle after the filtered pair changes.
REQ-026 SAT=0 wrap rules: 2^WIDTH-1 +1 -> 0; 0 -1 -> 2^WIDTH-1.
REQ-027 SAT=1 limit rules: value holds at its limit, while step and dir still update.
REQ-028 clear shall set value to 0 and suppress step that cycle, taking priority over a simultaneous event; dir is unaffected.
REQ-029 err_clr shall clear error; a new illegal transition in the same cycle shall win and leave error=1.
REQ-030 End-to-end latency from a clean input edge to step shall be 2 (sync) + FILTER + 1 (decode register) cycles.

Reset
REQ-031 While reset=1, all of the following shall be 0: synchronizers, filtered bits, stability counters, {oa,ob}, value, step, dir and error.
REQ-032 A startup counter shall run for FILTER+3 cycles after reset release. During that window:
- the filter is bypassed;
- {oa,ob} tracks the filtered pair;
- no count and no error is generated.
This prevents spurious events from non-00 input levels at power-up.
REQ-033 Reset asserted mid-operation shall immediately zero all outputs and restart the startup window.

Verification
REQ-034 Startup: reset released with a=b=1 held -> after the startup window, value=0, error=0, step never pulsed.
REQ-035 RES=4, FILTER=0: apply one full CW Gray cycle, then one full CCW Gray cycle -> value 0->4->0; 8 step pulses; dir=1 after the CW cycle, then 0.
REQ-036 RES=2, FILTER=4: a glitch of 3 cycles on a -> no step; a clean edge on a -> step exactly 7 cycles after the edge.
REQ-037 WIDTH=8, RES=4: value=255 plus one CW step -> SAT=0 gives 0; SAT=1 gives 255 with step=1 and dir=1.
REQ-038 Force AB 00->11 in one cycle -> error=1, value unchanged; err_clr asserted together with a second 11->00 violation -> error stays 1; err_clr alone -> error=0.
REQ-039 clear asserted in the same cycle as a counted CW event with value=5 -> value=0, step=0.
